// File: rtl/l2_cache_types_pkg.sv
// Shared types for the L2 cache controller: FSM states, counter width, saturating increment.
package l2_cache_types_pkg;

  localparam int unsigned CNT_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    TAG_CHECK,
    WRITEBACK,
    FILL,
    DONE
  } l2_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/l2_perf_counter.sv
// Saturating performance counter with enable and a synchronous preload.
module l2_perf_counter
  import l2_cache_types_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  // Count register: preload wins over increment; increment saturates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en) begin
      r_count <= sat_inc(r_count);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/l2_cache_control.sv
// L2 cache controller: tag check, victim writeback, line fill, and perf counters.
module l2_cache_control
  import l2_cache_types_pkg::*;
#(
  parameter int unsigned s_index = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_read,
  input  logic             mem_write,
  output logic             mem_resp,
  input  logic             hit,
  input  logic             valid,
  input  logic             dirty,
  output logic             tag_load,
  output logic             data_load,
  output logic             valid_load,
  output logic             dirty_load,
  output logic             dirty_in,
  output logic             write_sel,
  output logic             addr_sel,
  output logic             pmem_read,
  output logic             pmem_write,
  input  logic             pmem_resp,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
  output logic [CNT_W-1:0] wb_count
);

  // The index width belongs to the datapath; the controller only guards its sanity.
  if (s_index < 1) begin : g_bad_index
    $error("l2_cache_control: s_index must be at least 1");
  end

  l2_state_t r_state;
  l2_state_t w_next_state;
  logic      w_hit_en;
  logic      w_miss_en;
  logic      w_wb_en;

  // State register; async reset returns to IDLE, which drives every output low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and output decode; a write (including read+write) takes the write path.
  always_comb begin
    w_next_state = r_state;
    mem_resp     = 1'b0;
    tag_load     = 1'b0;
    data_load    = 1'b0;
    valid_load   = 1'b0;
    dirty_load   = 1'b0;
    dirty_in     = 1'b0;
    write_sel    = 1'b0;
    addr_sel     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    w_hit_en     = 1'b0;
    w_miss_en    = 1'b0;
    w_wb_en      = 1'b0;

    case (r_state)
      IDLE: begin
        if (mem_read || mem_write) begin
          w_next_state = TAG_CHECK;
        end
      end

      TAG_CHECK: begin
        if (valid && hit) begin
          mem_resp     = 1'b1;
          w_hit_en     = 1'b1;
          w_next_state = IDLE;
          if (mem_write) begin
            data_load  = 1'b1;
            write_sel  = 1'b1;
            dirty_load = 1'b1;
            dirty_in   = 1'b1;
          end
        end else begin
          w_miss_en    = 1'b1;
          w_next_state = (valid && dirty) ? WRITEBACK : FILL;
        end
      end

      WRITEBACK: begin
        pmem_write = 1'b1;
        addr_sel   = 1'b1;
        if (pmem_resp) begin
          w_wb_en      = 1'b1;
          w_next_state = FILL;
        end
      end

      FILL: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          tag_load     = 1'b1;
          data_load    = 1'b1;
          valid_load   = 1'b1;
          dirty_load   = 1'b1;
          dirty_in     = mem_write;
          write_sel    = mem_write;
          w_next_state = DONE;
        end
      end

      DONE: begin
        mem_resp     = 1'b1;
        w_next_state = IDLE;
      end

      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Performance counters; preload is unused in the controller.
  l2_perf_counter u_hit_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_en       (w_hit_en),
    .i_load     (1'b0),
    .i_load_val ('0),
    .o_count    (hit_count)
  );

  l2_perf_counter u_miss_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_en       (w_miss_en),
    .i_load     (1'b0),
    .i_load_val ('0),
    .o_count    (miss_count)
  );

  l2_perf_counter u_wb_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_en       (w_wb_en),
    .i_load     (1'b0),
    .i_load_val ('0),
    .o_count    (wb_count)
  );

endmodule

// File: tb/tb_l2_cache_control.sv
// Bench for l2_cache_control: vector table of transactions plus reset and saturation sequences.
module tb_l2_cache_control;
  import l2_cache_types_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic             mem_read, mem_write, mem_resp;
  logic             hit, valid, dirty;
  logic             tag_load, data_load, valid_load, dirty_load, dirty_in, write_sel, addr_sel;
  logic             pmem_read, pmem_write, pmem_resp;
  logic [CNT_W-1:0] hit_count, miss_count, wb_count;

  logic             sat_en, sat_load;
  logic [CNT_W-1:0] sat_val, sat_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_hit  = 0;
  int exp_miss = 0;
  int exp_wb   = 0;

  // Expected {data_load, write_sel, dirty_in, pmem_busy} at each mem_resp pulse.
  logic [3:0] sb_q[$];
  logic [3:0] sb_e;

  typedef struct {
    int rd, wr, v, h, d, drop, lat;
    int e_hit, e_wb, e_wr;
  } vec_t;

  vec_t vecs[9];

  always #5 clk = ~clk;

  l2_cache_control #(.s_index(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_resp   (mem_resp),
    .hit        (hit),
    .valid      (valid),
    .dirty      (dirty),
    .tag_load   (tag_load),
    .data_load  (data_load),
    .valid_load (valid_load),
    .dirty_load (dirty_load),
    .dirty_in   (dirty_in),
    .write_sel  (write_sel),
    .addr_sel   (addr_sel),
    .pmem_read  (pmem_read),
    .pmem_write (pmem_write),
    .pmem_resp  (pmem_resp),
    .hit_count  (hit_count),
    .miss_count (miss_count),
    .wb_count   (wb_count)
  );

  l2_perf_counter u_sat (
    .clk        (clk),
    .reset      (reset),
    .i_en       (sat_en),
    .i_load     (sat_load),
    .i_load_val (sat_val),
    .o_count    (sat_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int rd, wr, v, h, d, drop, lat, e_hit, e_wb, e_wr);
    vec_t t;
    t.rd = rd; t.wr = wr; t.v = v; t.h = h; t.d = d; t.drop = drop; t.lat = lat;
    t.e_hit = e_hit; t.e_wb = e_wb; t.e_wr = e_wr;
    return t;
  endfunction

  // Response monitor: pops the scoreboard on every mem_resp and checks pmem exclusivity.
  always @(negedge clk) begin
    chk("pmem_exclusive", 32'(pmem_read & pmem_write), 32'(0));
    if (mem_resp) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_mem_resp: got 1 expected 0 at %0t", $time);
      end else begin
        sb_e = sb_q.pop_front();
        chk("resp_payload", 32'({data_load, write_sel, dirty_in, pmem_read | pmem_write}), 32'(sb_e));
      end
    end
  end

  // Hold pmem_resp off for lat cycles of the current state, then pulse it once.
  task automatic pmem_reply(input int lat, input bit is_fill, input int e_wr);
    for (int i = 0; i < lat; i++) @(posedge clk);
    #1 pmem_resp = 1'b1;
    @(negedge clk);
    if (is_fill) begin
      chk("fill_loads", 32'({tag_load, data_load, valid_load, dirty_load}), 32'(4'hF));
      chk("fill_merge", 32'({dirty_in, write_sel}), 32'({e_wr != 0, e_wr != 0}));
      chk("fill_pmem_held", 32'({pmem_read, pmem_write, mem_resp}), 32'(3'b100));
    end else begin
      chk("wb_no_loads", 32'({tag_load, data_load, valid_load, dirty_load, mem_resp}), 32'(0));
      chk("wb_pmem_held", 32'({pmem_write, pmem_read, addr_sel}), 32'(3'b101));
    end
    @(posedge clk);
    #1 pmem_resp = 1'b0;
  endtask

  // One full request; entered and left at posedge+1 in IDLE.
  task automatic run_txn(input vec_t v);
    mem_read  = (v.rd != 0);
    mem_write = (v.wr != 0);
    valid     = (v.v != 0);
    hit       = (v.h != 0);
    dirty     = (v.d != 0);
    sb_q.push_back((v.e_hit != 0 && v.e_wr != 0) ? 4'b1110 : 4'b0000);
    @(posedge clk);
    @(negedge clk);
    if (v.e_hit != 0) begin
      chk("tc_hit_no_pmem", 32'({pmem_read, pmem_write, tag_load, valid_load}), 32'(0));
    end else begin
      chk("tc_miss_quiet", 32'({mem_resp, tag_load, data_load, valid_load, dirty_load}), 32'(0));
    end
    @(posedge clk);
    #1;
    if (v.e_hit == 0) begin
      if (v.drop != 0) begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
      end
      if (v.e_wb != 0) begin
        @(negedge clk);
        chk("wb_req", 32'({pmem_write, pmem_read, addr_sel}), 32'(3'b101));
        pmem_reply(v.lat, 1'b0, 0);
      end
      @(negedge clk);
      chk("fill_req", 32'({pmem_read, pmem_write, addr_sel}), 32'(3'b100));
      pmem_reply(v.lat, 1'b1, v.e_wr);
      @(negedge clk);
      chk("done_no_pmem", 32'({pmem_read, pmem_write, tag_load, valid_load}), 32'(0));
      @(posedge clk);
      #1;
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
    exp_hit  += v.e_hit;
    exp_miss += (v.e_hit == 0) ? 1 : 0;
    exp_wb   += v.e_wb;
    @(negedge clk);
    chk("hit_count", hit_count, 32'(exp_hit));
    chk("miss_count", miss_count, 32'(exp_miss));
    chk("wb_count", wb_count, 32'(exp_wb));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //          rd wr v  h  d  drop lat  hit wb wr
    vecs[0] = mk(1, 0, 1, 1, 0, 0, 1,   1, 0, 0); // read hit
    vecs[1] = mk(0, 1, 1, 1, 0, 0, 1,   1, 0, 1); // write hit
    vecs[2] = mk(1, 0, 0, 0, 0, 0, 5,   0, 0, 0); // clean read miss, invalid line
    vecs[3] = mk(0, 1, 1, 0, 1, 0, 3,   0, 1, 1); // dirty write miss
    vecs[4] = mk(1, 1, 1, 1, 1, 0, 1,   1, 0, 1); // read+write -> write hit
    vecs[5] = mk(1, 0, 1, 0, 0, 0, 2,   0, 0, 0); // valid clean miss
    vecs[6] = mk(1, 0, 0, 1, 1, 0, 2,   0, 0, 0); // invalid line ignores hit/dirty
    vecs[7] = mk(1, 0, 1, 0, 1, 0, 1,   0, 1, 0); // dirty read miss
    vecs[8] = mk(1, 0, 0, 0, 0, 1, 4,   0, 0, 0); // request dropped after tag check

    reset = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; hit = 1'b0; valid = 1'b0; dirty = 1'b0;
    pmem_resp = 1'b0;
    sat_en = 1'b0; sat_load = 1'b0; sat_val = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 32'({mem_resp, tag_load, data_load, valid_load, dirty_load, dirty_in,
                              write_sel, addr_sel, pmem_read, pmem_write}), 32'(0));
    chk("reset_counters", hit_count | miss_count | wb_count, 32'(0));

    // Release reset with the first request already presented.
    @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 9; i++) run_txn(vecs[i]);

    // Reset pulse in the middle of a fill.
    mem_read = 1'b1; valid = 1'b0; hit = 1'b0; dirty = 1'b0;
    sb_q.push_back(4'b0000);
    @(posedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("fill_before_reset", 32'(pmem_read), 32'(1));
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("reset_drops_pmem", 32'({pmem_read, pmem_write}), 32'(0));
    chk("reset_no_loads", 32'({tag_load, data_load, valid_load, dirty_load, mem_resp}), 32'(0));
    chk("reset_clears_hits", hit_count, 32'(0));
    chk("reset_clears_misses", miss_count | wb_count, 32'(0));
    sb_q.delete();
    mem_read = 1'b0;
    exp_hit = 0; exp_miss = 0; exp_wb = 0;
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("post_reset_idle", 32'({pmem_read, pmem_write, mem_resp}), 32'(0));
    @(posedge clk);
    #1;
    run_txn(vecs[0]);

    // Saturation: preload one below max, then two enabled cycles.
    sat_val = 32'hFFFF_FFFE;
    sat_load = 1'b1;
    @(posedge clk);
    #1 sat_load = 1'b0;
    @(negedge clk);
    chk("sat_preload", sat_count, 32'hFFFF_FFFE);
    @(posedge clk);
    #1 sat_en = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("sat_reach_max", sat_count, 32'hFFFF_FFFF);
    @(posedge clk);
    #1 sat_en = 1'b0;
    @(negedge clk);
    chk("sat_hold_max", sat_count, 32'hFFFF_FFFF);

    chk("scoreboard_drained", 32'(sb_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
